// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared types and defaults for the MIPS multi-cycle memory port
package mips_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int WORD_W              = 32;
    localparam int DEFAULT_DEPTH_WORDS = 1024;
    localparam int DEFAULT_WAIT_CYCLES = 2;

endpackage

// File: rtl/mips_mem_array.sv
// rtl/mips_mem_array.sv - single-port word RAM with enable-gated write and registered read
module mips_mem_array
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH_WORDS,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rdata_q, rdata_d;

    // Storage is deliberately not reset; only the read register is.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem_q[addr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (en && !we) begin
            rdata_d = mem_q[addr];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mips_mem_port.sv
// rtl/mips_mem_port.sv - wait-stated memory port for the multi-cycle MIPS core
// Optional MEM_ALIGN_CHECK_EN adds the misalign output and suppresses misaligned accesses.
module mips_mem_port
    import mips_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [WORD_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
`ifdef MEM_ALIGN_CHECK_EN
    output logic              misalign,
`endif
    output logic              ready,
    output logic              busy
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              is_write_q, is_write_d;
    logic              req;
    logic              done_entry;
    logic              ram_en;

    assign req = mem_read | mem_write;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        is_write_d = is_write_q;
        done_entry = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    idx_d      = addr[AW+1:2];
                    wdata_d    = wdata;
                    is_write_d = mem_write;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = ST_DONE;
                        done_entry = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = ST_DONE;
                    done_entry = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            idx_q      <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            is_write_q <= is_write_d;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic mis_q, mis_d;
    logic misalign_q, misalign_d;
    logic unused_addr_bits;

    always_comb begin
        mis_d = mis_q;
        if (state_q == ST_IDLE && req) begin
            mis_d = (addr[1:0] != 2'b00);
        end
        misalign_d = done_entry & mis_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mis_q      <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            mis_q      <= mis_d;
            misalign_q <= misalign_d;
        end
    end

    // A misaligned access still completes its handshake but never touches the RAM.
    assign ram_en           = done_entry & rst & ~mis_d;
    assign misalign         = misalign_q;
    assign unused_addr_bits = ^addr[WORD_W-1:AW+2];
`else
    logic unused_addr_bits;

    assign ram_en           = done_entry & rst;
    assign unused_addr_bits = ^{addr[WORD_W-1:AW+2], addr[1:0]};
`endif

    // The _d capture values are the live inputs on a zero-wait accept and the held ones otherwise.
    mips_mem_array #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .en    (ram_en),
        .we    (is_write_d),
        .addr  (idx_d),
        .wdata (wdata_d),
        .rdata (rdata)
    );

    assign ready = (state_q == ST_DONE);
    assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mips_mem_port.sv
// tb/tb_mips_mem_port.sv - scoreboard bench for mips_mem_port (WAIT_CYCLES 2 and 0)
module tb_mips_mem_port;

    typedef struct {
        logic        is_read;
        logic [31:0] rdata;
        int          rdy_cyc;
        logic        mis;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rd  [2];
    logic        wr  [2];
    logic [31:0] ad  [2];
    logic [31:0] wd  [2];
    logic [31:0] rdo [2];
    logic        rdy [2];
    logic        bsy [2];
`ifdef MEM_ALIGN_CHECK_EN
    logic        mis [2];
    localparam logic MIS_EXP = 1'b1;
    localparam logic [31:0] ALIGN_RD_EXP = 32'h0102_0304;
`else
    localparam logic MIS_EXP = 1'b0;
    localparam logic [31:0] ALIGN_RD_EXP = 32'hCAFE_F00D;
`endif

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    mips_mem_port #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut_w2 (
        .clk(clk), .rst(rst), .mem_read(rd[0]), .mem_write(wr[0]), .addr(ad[0]), .wdata(wd[0]),
        .rdata(rdo[0]),
`ifdef MEM_ALIGN_CHECK_EN
        .misalign(mis[0]),
`endif
        .ready(rdy[0]), .busy(bsy[0])
    );

    mips_mem_port #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .rst(rst), .mem_read(rd[1]), .mem_write(wr[1]), .addr(ad[1]), .wdata(wd[1]),
        .rdata(rdo[1]),
`ifdef MEM_ALIGN_CHECK_EN
        .misalign(mis[1]),
`endif
        .ready(rdy[1]), .busy(bsy[1])
    );

    function automatic int wc(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Monitor: every ready pulse pops one expectation
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (rst && rdy[d]) begin
                if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                    chk($sformatf("unexpected_ready_dut%0d", d), 32'd1, 32'd0);
                end else begin
                    if (d == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    chk($sformatf("latency_dut%0d", d), cyc, e.rdy_cyc);
                    chk($sformatf("busy_in_ready_dut%0d", d), {31'd0, bsy[d]}, 32'd1);
                    if (e.is_read) chk($sformatf("rdata_dut%0d", d), rdo[d], e.rdata);
`ifdef MEM_ALIGN_CHECK_EN
                    chk($sformatf("misalign_dut%0d", d), {31'd0, mis[d]}, {31'd0, e.mis});
`endif
                end
            end
        end
    end

    // Call at posedge+#1 with the DUT in IDLE; that cycle becomes the accept cycle.
    task automatic acc(input int d, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] data, input logic [31:0] exp_rd, input logic exp_mis);
        exp_t e;
        int   t;
        e.is_read = r && !w;
        e.rdata   = exp_rd;
        e.rdy_cyc = cyc + wc(d) + 1;
        e.mis     = exp_mis;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
        rd[d] = r;
        wr[d] = w;
        ad[d] = a;
        wd[d] = data;
        @(posedge clk);
        #1;
        ad[d] = ~a;
        wd[d] = ~data;
        t = 0;
        @(negedge clk);
        while (!rdy[d] && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (!rdy[d]) chk($sformatf("ready_timeout_dut%0d", d), 32'd0, 32'd1);
        @(posedge clk);
        #1;
        rd[d] = 1'b0;
        wr[d] = 1'b0;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rd[d] = 1'b0;
            wr[d] = 1'b0;
            ad[d] = '0;
            wd[d] = '0;
        end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            chk("reset_rdata", rdo[d], 32'h0);
            chk("reset_ready", {31'd0, rdy[d]}, 32'd0);
            chk("reset_busy", {31'd0, bsy[d]}, 32'd0);
        end

        acc(0, 1'b0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0, 1'b0);
        acc(0, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 1'b0);
        acc(0, 1'b1, 1'b1, 32'h1000_0004, 32'h1234_5678, 32'h0, 1'b0);
        acc(0, 1'b1, 1'b0, 32'h0000_0004, 32'h0, 32'h1234_5678, 1'b0);
        acc(0, 1'b0, 1'b1, 32'h0000_0008, 32'h1111_1111, 32'h0, 1'b0);

        // Start a write, then reset while it is waiting
        wr[0] = 1'b1;
        ad[0] = 32'h0000_0008;
        wd[0] = 32'hAAAA_5555;
        @(posedge clk);
        #1;
        chk("busy_before_abort", {31'd0, bsy[0]}, 32'd1);
        rst = 1'b0;
        #1;
        chk("abort_busy", {31'd0, bsy[0]}, 32'd0);
        chk("abort_ready", {31'd0, rdy[0]}, 32'd0);
        chk("abort_rdata", rdo[0], 32'h0);
        wr[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        acc(0, 1'b1, 1'b0, 32'h0000_0008, 32'h0, 32'h1111_1111, 1'b0);

        acc(0, 1'b0, 1'b1, 32'h0000_0040, 32'h0102_0304, 32'h0, 1'b0);
        acc(0, 1'b0, 1'b1, 32'h0000_0042, 32'hCAFE_F00D, 32'h0, MIS_EXP);
        acc(0, 1'b1, 1'b0, 32'h0000_0040, 32'h0, ALIGN_RD_EXP, 1'b0);

        acc(1, 1'b0, 1'b1, 32'h0000_0000, 32'h5A5A_5A5A, 32'h0, 1'b0);
        acc(1, 1'b1, 1'b0, 32'h0000_0000, 32'h0, 32'h5A5A_5A5A, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_drained", q0.size() + q1.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
